instr_mem_arbiter: RTL and testbench

INSTR_MEM_ARBITER -- requirements
Module: instr_mem_arbiter

---
 rtl/instr_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_instr_mem_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/instr_mem_arbiter.sv
// Arbitrates a single-port instruction memory between a CPU fetch port and a boot loader.
// BOOT gives the loader exclusive access; RUN favours fetch with bounded loader starvation.
module instr_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 2048,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_gnt,
  input  logic              boot_mode,
  output logic              boot_done,
  output logic              addr_err,
  output logic              mem_rd,
  output logic              mem_wn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  state_e         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           fetch_valid_q, fetch_oor_q, boot_done_q, addr_err_q;
  logic           boot_done_d, addr_err_d;
  logic           fetch_gnt_s, load_gnt_s;
  logic           fetch_in_range_s, load_in_range_s;

  assign fetch_in_range_s = (32'(fetch_addr) < 32'(DEPTH));
  assign load_in_range_s  = (32'(load_addr) < 32'(DEPTH));

  // Grants are combinational but must read as zero for the whole reset window.
  assign fetch_gnt = fetch_gnt_s & ~reset;
  assign load_gnt  = load_gnt_s & ~reset;

  always_comb begin
    state_d     = state_q;
    fetch_gnt_s = 1'b0;
    load_gnt_s  = 1'b0;
    boot_done_d = 1'b0;
    case (state_q)
      BOOT: begin
        load_gnt_s = load_req;
        if (!boot_mode && !load_req) begin
          state_d     = RUN;
          boot_done_d = 1'b1;
        end else begin
          state_d = BOOT;
        end
      end
      RUN: begin
        if (fetch_req && load_req) begin
          if (wait_cnt_q == WAIT_MAX) begin
            load_gnt_s = 1'b1;
          end else begin
            fetch_gnt_s = 1'b1;
          end
        end else begin
          fetch_gnt_s = fetch_req;
          load_gnt_s  = load_req;
        end
        if (boot_mode) begin
          state_d = BOOT;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_comb begin
    if (!load_req || load_gnt_s) begin
      wait_cnt_d = {WCW{1'b0}};
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Out-of-range grants keep the address visible but suppress the strobes.
  always_comb begin
    mem_rd         = 1'b0;
    mem_wn         = 1'b0;
    mem_address    = {ADDR_W{1'b0}};
    mem_write_data = {DATA_W{1'b0}};
    if (fetch_gnt) begin
      mem_rd      = fetch_in_range_s;
      mem_address = fetch_addr;
    end else if (load_gnt) begin
      mem_wn         = load_in_range_s;
      mem_address    = load_addr;
      mem_write_data = load_data;
    end else begin
      mem_rd = 1'b0;
    end
  end

  assign addr_err_d = addr_err_q
                    | (fetch_gnt & ~fetch_in_range_s)
                    | (load_gnt & ~load_in_range_s);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      wait_cnt_q    <= {WCW{1'b0}};
      fetch_valid_q <= 1'b0;
      fetch_oor_q   <= 1'b0;
      boot_done_q   <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      fetch_valid_q <= fetch_gnt;
      fetch_oor_q   <= fetch_gnt & ~fetch_in_range_s;
      boot_done_q   <= boot_done_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = (fetch_valid_q && !fetch_oor_q) ? mem_read_data : {DATA_W{1'b0}};
  assign boot_done   = boot_done_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed bench for instr_mem_arbiter with a behavioural single-port memory attached.
module tb_instr_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, load_req, boot_mode;
  logic [15:0] fetch_addr, load_addr;
  logic [31:0] load_data;
  logic        fetch_gnt, fetch_valid, load_gnt, boot_done, addr_err, mem_rd, mem_wn;
  logic [31:0] fetch_data, mem_write_data;
  logic [15:0] mem_address;
  logic [31:0] mem_read_data = 32'h0;
  logic [31:0] mem_model [0:2047];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data), .load_gnt(load_gnt),
    .boot_mode(boot_mode), .boot_done(boot_done), .addr_err(addr_err),
    .mem_rd(mem_rd), .mem_wn(mem_wn), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Synchronous memory: read data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_wn) mem_model[mem_address[10:0]] <= mem_write_data;
    if (mem_rd) mem_read_data <= mem_model[mem_address[10:0]];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_fetch_gnt"}, fetch_gnt, 1'b0);
    check({tag, "_load_gnt"}, load_gnt, 1'b0);
    check({tag, "_mem_rd"}, mem_rd, 1'b0);
    check({tag, "_mem_wn"}, mem_wn, 1'b0);
    check({tag, "_mem_address"}, mem_address, 16'h0);
    check({tag, "_mem_write_data"}, mem_write_data, 32'h0);
    check({tag, "_fetch_valid"}, fetch_valid, 1'b0);
    check({tag, "_fetch_data"}, fetch_data, 32'h0);
    check({tag, "_boot_done"}, boot_done, 1'b0);
    check({tag, "_addr_err"}, addr_err, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem_model[i] = 32'h0;
    reset = 1'b1; boot_mode = 1'b1;
    fetch_req = 1'b1; fetch_addr = 16'd7;
    load_req = 1'b1; load_addr = 16'd3; load_data = 32'h11111111;
    next_cycle(); next_cycle(); #1;
    check_idle_outputs("reset");

    // Boot load: loader owns the memory, fetch held off
    next_cycle();
    reset = 1'b0; load_addr = 16'd5; load_data = 32'hDEADBEEF; #1;
    check("boot_load_gnt", load_gnt, 1'b1);
    check("boot_mem_wn", mem_wn, 1'b1);
    check("boot_mem_rd", mem_rd, 1'b0);
    check("boot_mem_address", mem_address, 16'd5);
    check("boot_mem_wdata", mem_write_data, 32'hDEADBEEF);
    check("boot_fetch_gnt", fetch_gnt, 1'b0);
    next_cycle();
    load_addr = 16'd6; load_data = 32'h12345678; #1;
    check("boot2_load_gnt", load_gnt, 1'b1);
    check("boot2_fetch_gnt", fetch_gnt, 1'b0);
    next_cycle();
    load_req = 1'b0; #1;
    check("boot_idle_fetch_gnt", fetch_gnt, 1'b0);
    check("boot_idle_mem_address", mem_address, 16'h0);
    check("boot_idle_mem_wn", mem_wn, 1'b0);

    // Exit boot, then read back the loaded words back to back
    next_cycle();
    boot_mode = 1'b0; fetch_addr = 16'd5; #1;
    check("exit_fetch_gnt", fetch_gnt, 1'b0);
    check("exit_boot_done", boot_done, 1'b0);
    next_cycle(); #1;
    check("run_boot_done", boot_done, 1'b1);
    check("run_fetch_gnt", fetch_gnt, 1'b1);
    check("run_mem_rd", mem_rd, 1'b1);
    check("run_mem_address", mem_address, 16'd5);
    next_cycle();
    fetch_addr = 16'd6; #1;
    check("b2b_boot_done_low", boot_done, 1'b0);
    check("b2b_valid1", fetch_valid, 1'b1);
    check("b2b_data1", fetch_data, 32'hDEADBEEF);
    check("b2b_fetch_gnt2", fetch_gnt, 1'b1);
    next_cycle();
    fetch_req = 1'b0; #1;
    check("b2b_valid2", fetch_valid, 1'b1);
    check("b2b_data2", fetch_data, 32'h12345678);
    check("noreq_fetch_gnt", fetch_gnt, 1'b0);
    check("noreq_mem_address", mem_address, 16'h0);
    next_cycle(); #1;
    check("idle_valid", fetch_valid, 1'b0);
    check("idle_data", fetch_data, 32'h0);

    // Starvation guard: load wins every fifth cycle under constant contention
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      fetch_req = 1'b1; fetch_addr = 16'd5;
      load_req = 1'b1; load_addr = 16'd9; load_data = 32'hA5A5A5A5; #1;
      check($sformatf("starve_fetch_gnt_%0d", k), fetch_gnt, (k % 5) != 4);
      check($sformatf("starve_load_gnt_%0d", k), load_gnt, (k % 5) == 4);
    end
    next_cycle();
    fetch_req = 1'b0; #1;
    check("load_only_gnt", load_gnt, 1'b1);
    check("load_only_mem_wn", mem_wn, 1'b1);

    // Address range boundary and sticky error
    next_cycle();
    load_req = 1'b0; fetch_req = 1'b1; fetch_addr = 16'd2047; #1;
    check("edge_addr_err", addr_err, 1'b0);
    check("edge_mem_rd", mem_rd, 1'b1);
    next_cycle();
    fetch_addr = 16'd2048; #1;
    check("oor_fetch_gnt", fetch_gnt, 1'b1);
    check("oor_mem_rd", mem_rd, 1'b0);
    check("oor_mem_address", mem_address, 16'd2048);
    next_cycle();
    fetch_req = 1'b0; #1;
    check("oor_valid", fetch_valid, 1'b1);
    check("oor_data", fetch_data, 32'h0);
    check("oor_addr_err", addr_err, 1'b1);
    next_cycle();
    load_req = 1'b1; load_addr = 16'd4000; load_data = 32'h1; #1;
    check("oor_load_gnt", load_gnt, 1'b1);
    check("oor_load_mem_wn", mem_wn, 1'b0);
    check("sticky_addr_err", addr_err, 1'b1);

    // RUN->BOOT: the granted fetch still completes
    next_cycle();
    load_req = 1'b0; boot_mode = 1'b1; fetch_req = 1'b1; fetch_addr = 16'd5; #1;
    check("toboot_fetch_gnt", fetch_gnt, 1'b1);
    next_cycle(); #1;
    check("inboot_fetch_gnt", fetch_gnt, 1'b0);
    check("inboot_valid", fetch_valid, 1'b1);
    check("inboot_data", fetch_data, 32'hDEADBEEF);

    // Reset the cycle after a fetch grant
    next_cycle();
    boot_mode = 1'b0; #1;
    check("reboot_fetch_gnt", fetch_gnt, 1'b0);
    next_cycle(); #1;
    check("rerun_fetch_gnt", fetch_gnt, 1'b1);
    next_cycle();
    reset = 1'b1; #1;
    check_idle_outputs("midreset");
    next_cycle();
    reset = 1'b0; #1;
    check("postreset_boot_fetch_gnt", fetch_gnt, 1'b0);
    next_cycle(); #1;
    check("postreset_run_fetch_gnt", fetch_gnt, 1'b1);
    check("postreset_boot_done", boot_done, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
